// File: rtl/store_merge_unit.sv
// Store merge unit: takes sb/sh/sw requests from execute and writes full words to data RAM,
// read-modify-writing the containing word for sub-word stores.
module store_merge_unit #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              rd_en_q, rd_en_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_c;
    logic              bad_c;
    logic [31:0]       merged_c;

    // Address bits above the memory size wrap and are intentionally dropped.
    logic              unused_addr_hi_c;
    assign unused_addr_hi_c = ^req_addr[31:ADDR_W+2];

    assign accept_c = req_valid && ready_q;

    always_comb begin
        bad_c = 1'b1;
        case (req_funct3)
            F3_SB:   bad_c = 1'b0;
            F3_SH:   bad_c = req_addr[0];
            F3_SW:   bad_c = (req_addr[1:0] != 2'b00);
            default: bad_c = 1'b1;
        endcase
    end

    // Splice the latched store lane into the word read back from memory.
    always_comb begin
        merged_c = mem_rdata;
        if (f3_q == F3_SB) begin
            merged_c[{off_q, 3'b000} +: 8] = data_q[7:0];
        end else begin
            merged_c[{off_q[1], 4'b0000} +: 16] = data_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_en_d = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        f3_d   = req_funct3;
                        off_d  = req_addr[1:0];
                        data_d = req_data[15:0];
                        addr_d = req_addr[ADDR_W+1:2];
                        if (req_funct3 == F3_SW) begin
                            wdata_d = req_data;
                            we_d    = 1'b1;
                            state_d = S_WRITE;
                        end else begin
                            rd_en_d = 1'b1;
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    wdata_d = merged_c;
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            rd_en_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rd_en_q <= rd_en_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign mem_addr  = addr_q;
    assign mem_rd_en = rd_en_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
